tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: the receive end of a slotted serial stream in which a mux-based transmitter sends one W-bit sample per beat, round-robin over N_CH channels, marking slot 0 with a start-of-frame flag. The block locks to frames, steers each beat to its channel register, reports completed frames, and detects and recovers from loss of frame alignment. It sits between the serial link and per-channel consumers.

## Interface
- N_CH, 4: number of channels (slots per frame), ≥ 2.
- W, 8: sample width in bits.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat present this cycle.
- in_sof  in  1  beat is slot 0; ignored when in_valid=0.
- in_data  in  W  beat payload.
- out_data  out  N_CH*W  channel k at bits [k*W +: W].
- out_valid  out  N_CH  per-channel one-cycle update strobe.
- frame_done  out  1  one-cycle pulse: slot N_CH-1 accepted.
- sync_err  out  1  one-cycle pulse: alignment violation.
- locked  out  1  high in LOCKED state.

## Operation
- State machine: HUNT, LOCKED. Slot counter `slot`, width $clog2(N_CH), range 0..N_CH-1.
- HUNT: in_valid && !in_sof -> beat dropped, no outputs. in_valid && in_sof -> beat captured as slot 0, slot=1, go LOCKED.
- LOCKED, in_valid, slot≠0, !in_sof: capture as channel `slot`; if slot==N_CH-1, pulse frame_done and wrap slot to 0, else slot+1.
- LOCKED, in_valid, slot==0, in_sof: capture as channel 0, slot=1.
- LOCKED, in_valid, slot≠0, in_sof (early SOF): pulse sync_err, capture beat as channel 0, slot=1 (resync; stay LOCKED).
- LOCKED, in_valid, slot==0, !in_sof (missing SOF): pulse sync_err, drop beat, slot=0, go HUNT.
- in_valid=0: no state change, no strobes; gaps between beats of any length are legal.
- Capture: out_data channel k <= in_data, out_valid[k] pulses (per-slot mode; see Configuration).
- Channels not written keep their last value.

## Timing
- All outputs registered; latency 1 cycle from accepted beat to out_data/out_valid/frame_done/sync_err.
- Reset (async assert, sync deassert handled by system): out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0, state HUNT, slot=0.
- Reset mid-frame: partial frame discarded; first post-reset beat must carry in_sof to lock.
- frame_done and the out_valid strobe for slot N_CH-1 assert in the same cycle.
- sync_err and a resync capture strobe (out_valid[0]) may assert in the same cycle.
- Back-to-back frames at one beat per cycle sustained with no bubble.
- locked reflects state after the edge (registered).

## Configuration
- TDM_DEMUX_FRAME_BUF_EN defined: beats accumulate in an internal shadow register; out_data updates all channels atomically one cycle after slot N_CH-1 is accepted, with out_valid = all ones for that single cycle, coincident with frame_done. Partial frames aborted by early SOF, missing SOF, or reset are discarded; out_data unchanged.
- Undefined: per-slot mode as in Operation; no shadow register.

## Test plan
- Lock and capture (N_CH=4, W=8): reset, then beats 0x11(sof),0x22,0x33,0x44 -> out_data=0x44332211, out_valid strobes 0001,0010,0100,1000 one cycle after each beat, frame_done with last, locked=1.
- Hunt drop: beats 0xAA,0xBB without sof, then 0x01(sof),0x02,0x03,0x04 -> first two ignored, out_data=0x04030201, sync_err never asserts.
- Early SOF: 0x11(sof),0x22, then 0x55(sof),0x66,0x77,0x88 -> sync_err one pulse on 0x55, final out_data=0x88776655, one frame_done.
- Missing SOF: full frame then 0x99 without sof -> sync_err pulse, locked=0, out_data unchanged; next 0x01(sof) relocks.
- Gaps and reset: frame with 3 idle cycles between beats completes identically; rst_n low after slot 1 -> all outputs 0 immediately, HUNT.
- With TDM_DEMUX_FRAME_BUF_EN: first scenario gives out_data=0 until last beat, then 0x44332211 with out_valid=1111 for one cycle; early-SOF aborted partial never appears on out_data.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a slotted TDM stream. Locks to frames on the
// start-of-frame flag, steers each beat to its channel register, pulses
// frame_done on the last slot and sync_err on alignment violations.
//
// Optional build macro: TDM_DEMUX_FRAME_BUF_EN
//   defined   -> beats collect in a shadow register; out_data updates all
//                channels at once when a frame completes (out_valid = all 1s).
//   undefined -> each channel register updates as its beat arrives.
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | not aligned; beats dropped until one arrives with in_sof
// LOCKED | aligned; slot counts the next expected slot index
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] out_data,
  output logic [N_CH-1:0]   out_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     slot, slot_nxt;
  logic              cap;
  logic [SW-1:0]     cap_ch;
  logic              done_nxt;
  logic              err_nxt;
  logic [N_CH*W-1:0] lanes_wr;
  logic [N_CH*W-1:0] out_data_q;
  logic [N_CH-1:0]   out_valid_q;
  logic              frame_done_q;
  logic              sync_err_q;

  // State and slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      slot  <= '0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Frame alignment: decide capture channel, next slot and event strobes.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cap       = 1'b0;
    cap_ch    = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_sof) begin
            cap       = 1'b1;
            slot_nxt  = SW'(1);
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == '0) begin
            if (in_sof) begin
              cap      = 1'b1;
              slot_nxt = SW'(1);
            end else begin
              // missing SOF: alignment lost, go back to hunting
              err_nxt   = 1'b1;
              slot_nxt  = '0;
              state_nxt = HUNT;
            end
          end else if (in_sof) begin
            // early SOF: trust the flag and restart the frame on this beat
            err_nxt  = 1'b1;
            cap      = 1'b1;
            slot_nxt = SW'(1);
          end else begin
            cap    = 1'b1;
            cap_ch = slot;
            if (slot == LAST_SLOT) begin
              done_nxt = 1'b1;
              slot_nxt = '0;
            end else begin
              slot_nxt = slot + SW'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

`ifdef TDM_DEMUX_FRAME_BUF_EN
  logic [N_CH*W-1:0] shadow;

  // Shadow frame with the current beat merged into its lane.
  always_comb begin
    lanes_wr = shadow;
    for (int k = 0; k < N_CH; k++)
      if (cap && (cap_ch == SW'(k))) lanes_wr[k*W +: W] = in_data;
  end

  // Accumulate beats; publish the whole frame when the last slot lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      shadow      <= lanes_wr;
      out_valid_q <= '0;
      if (done_nxt) begin
        out_data_q  <= lanes_wr;
        out_valid_q <= '1;
      end
    end
  end
`else
  logic [N_CH-1:0] strobe;

  // Current outputs with the captured beat merged into its lane.
  always_comb begin
    lanes_wr = out_data_q;
    strobe   = '0;
    for (int k = 0; k < N_CH; k++)
      if (cap && (cap_ch == SW'(k))) begin
        lanes_wr[k*W +: W] = in_data;
        strobe[k]          = 1'b1;
      end
  end

  // Per-slot update of the channel registers and their strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= '0;
    end else begin
      out_data_q  <= lanes_wr;
      out_valid_q <= strobe;
    end
  end
`endif

  // Registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= done_nxt;
      sync_err_q   <= err_nxt;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: a reference model pushes the expected
// outputs for every driven cycle into a queue; they are popped and compared
// one cycle later. Directed test-plan scenarios are followed by random beats.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_sof;
  logic [W-1:0]      in_data;
  logic [N_CH*W-1:0] out_data;
  logic [N_CH-1:0]   out_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH*W-1:0] data;
    logic [N_CH-1:0]   valid;
    logic              done;
    logic              err;
    logic              lk;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_err_seen = 0;
  int n_done_seen = 0;
  int n_valid_any = 0;

  // reference model state
  bit                m_locked;
  int                m_slot;
  logic [N_CH*W-1:0] m_data;
  logic [N_CH*W-1:0] m_shadow;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_slot   = 0;
    m_data   = '0;
    m_shadow = '0;
  endtask

  // Drive one cycle of input, predict, then compare the registered outputs.
  task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
    exp_t e;
    int   ch;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    e.valid = '0;
    e.done  = 1'b0;
    e.err   = 1'b0;
    ch = -1;
    if (v) begin
      if (!m_locked) begin
        if (s) begin ch = 0; m_slot = 1; m_locked = 1; end
      end else if (m_slot == 0) begin
        if (s) begin ch = 0; m_slot = 1; end
        else begin e.err = 1'b1; m_locked = 0; end
      end else if (s) begin
        e.err = 1'b1; ch = 0; m_slot = 1;
      end else begin
        ch = m_slot;
        if (m_slot == N_CH - 1) begin e.done = 1'b1; m_slot = 0; end
        else m_slot = m_slot + 1;
      end
    end
    if (ch >= 0) begin
`ifdef TDM_DEMUX_FRAME_BUF_EN
      m_shadow[ch*W +: W] = d;
      if (e.done) begin
        m_data  = m_shadow;
        e.valid = '1;
      end
`else
      m_data[ch*W +: W] = d;
      e.valid[ch] = 1'b1;
`endif
    end
    e.data = m_data;
    e.lk   = m_locked;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("out_data",   64'(out_data),   64'(e.data));
      chk("out_valid",  64'(out_valid),  64'(e.valid));
      chk("frame_done", 64'(frame_done), 64'(e.done));
      chk("sync_err",   64'(sync_err),   64'(e.err));
      chk("locked",     64'(locked),     64'(e.lk));
    end
    if (sync_err) n_err_seen++;
    if (frame_done) n_done_seen++;
    if (out_valid != '0) n_valid_any++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    model_reset();
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sync_err",   64'(sync_err),   64'd0);
    chk("rst_locked",     64'(locked),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // lock and capture
    n_done_seen = 0;
    beat(1, 1, 8'h11); beat(1, 0, 8'h22); beat(1, 0, 8'h33); beat(1, 0, 8'h44);
    chk("lock_data", 64'(out_data), 64'h44332211);
    chk("lock_done_cnt", 64'(n_done_seen), 64'd1);
    chk("lock_locked", 64'(locked), 64'd1);

    // hunt drop
    do_reset();
    n_err_seen = 0;
    n_valid_any = 0;
    beat(1, 0, 8'hAA); beat(1, 0, 8'hBB);
    chk("hunt_no_strobe", 64'(n_valid_any), 64'd0);
    beat(1, 1, 8'h01); beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);
    chk("hunt_data", 64'(out_data), 64'h04030201);
    chk("hunt_err_cnt", 64'(n_err_seen), 64'd0);

    // early SOF
    n_err_seen = 0;
    n_done_seen = 0;
    beat(1, 1, 8'h11); beat(1, 0, 8'h22);
    beat(1, 1, 8'h55);
    chk("early_err_pulse", 64'(sync_err), 64'd1);
    beat(1, 0, 8'h66); beat(1, 0, 8'h77); beat(1, 0, 8'h88);
    chk("early_data", 64'(out_data), 64'h88776655);
    chk("early_err_cnt", 64'(n_err_seen), 64'd1);
    chk("early_done_cnt", 64'(n_done_seen), 64'd1);

    // missing SOF then relock
    beat(1, 0, 8'h99);
    chk("miss_err", 64'(sync_err), 64'd1);
    chk("miss_locked", 64'(locked), 64'd0);
    chk("miss_data", 64'(out_data), 64'h88776655);
    beat(1, 1, 8'h01);
    chk("relock", 64'(locked), 64'd1);
    beat(1, 0, 8'h02); beat(1, 0, 8'h03); beat(1, 0, 8'h04);

    // gaps between beats
    beat(1, 1, 8'hA1); idle(3);
    beat(1, 0, 8'hB2); idle(3);
    beat(1, 0, 8'hC3); idle(3);
    beat(1, 0, 8'hD4);
    chk("gap_data", 64'(out_data), 64'hD4C3B2A1);

    // reset mid-frame, then a beat without sof must be dropped
    beat(1, 1, 8'h5A); beat(1, 0, 8'h6B);
    do_reset();
    beat(1, 0, 8'h77);
    chk("post_rst_locked", 64'(locked), 64'd0);
    beat(1, 1, 8'h10); beat(1, 0, 8'h20); beat(1, 0, 8'h30); beat(1, 0, 8'h40);
    chk("post_rst_data", 64'(out_data), 64'h40302010);

    // random traffic: mostly aligned frames with occasional faults and gaps
    begin
      int s;
      s = 0;
      for (int i = 0; i < 400; i++) begin
        logic v, f;
        v = ($urandom_range(0, 3) != 0);
        f = (s == 0);
        if ($urandom_range(0, 15) == 0) f = ~f;
        if (v) s = (f) ? 1 : ((s + 1) % N_CH);
        beat(v, f, W'($urandom));
      end
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
